// File: rtl/systolic_sequencer.sv
// Sequencer for an N x N weight-stationary systolic array: loads weight rows, streams
// skewed activation vectors into the left edge and writes deskewed column sums back.
module systolic_sequencer #(
    parameter int N         = 4,
    parameter int data_size = 8,
    parameter int ADDR_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         num_vec,
    output logic                      busy,
    output logic                      done,
    output logic                      w_rd_en,
    output logic [ADDR_W-1:0]         w_rd_addr,
    input  logic [N*data_size-1:0]    w_rd_data,
    output logic                      w_load,
    output logic [$clog2(N)-1:0]      w_row,
    output logic [N*data_size-1:0]    w_data,
    output logic                      act_rd_en,
    output logic [ADDR_W-1:0]         act_rd_addr,
    input  logic [N*data_size-1:0]    act_rd_data,
    output logic [N*data_size-1:0]    array_a,
    input  logic [N*data_size-1:0]    array_c_out,
    output logic                      res_wr_en,
    output logic [ADDR_W-1:0]         res_wr_addr,
    output logic [N*data_size-1:0]    res_wr_data
);

    localparam int PIPE = 2 * N + 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   m_reg;
    logic [ADDR_W-1:0]   m_last;
    logic                last_wr;
    logic                w_load_p0;
    logic [$clog2(N)-1:0] w_row_p0;
    logic                vld_p  [PIPE];
    logic [ADDR_W-1:0]   addr_p [PIPE];
    logic [N*data_size-1:0] res_cols;

    assign m_last  = m_reg - ADDR_W'(1);
    assign last_wr = res_wr_en && (res_wr_addr == m_last);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx    = state;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        act_rd_en   = 1'b0;
        act_rd_addr = '0;
        case (state)
            IDLE: begin
                if (start && (num_vec != '0)) state_nx = LOAD_W;
            end
            LOAD_W: begin
                w_rd_en   = 1'b1;
                w_rd_addr = cnt;
                if (cnt == ADDR_W'(N - 1)) state_nx = STREAM;
            end
            STREAM: begin
                act_rd_en   = 1'b1;
                act_rd_addr = cnt;
                if (cnt == m_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (last_wr) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            m_reg <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            // an empty job completes immediately; a real job completes on its last write
            done  <= ((state == IDLE) && start && (num_vec == '0)) ||
                     ((state == DRAIN) && last_wr);
            if ((state == IDLE) && start && (num_vec != '0)) m_reg <= num_vec;
            if (state != state_nx)
                cnt <= '0;
            else if ((state == LOAD_W) || (state == STREAM))
                cnt <= cnt + ADDR_W'(1);
        end
    end

    // p0: weight row returns one cycle after its read
    always_ff @(posedge clk) begin
        if (reset) begin
            w_load_p0 <= 1'b0;
            w_row_p0  <= '0;
        end else begin
            w_load_p0 <= w_rd_en;
            w_row_p0  <= w_rd_addr[$clog2(N)-1:0];
        end
    end

    assign w_load = w_load_p0;
    assign w_row  = w_row_p0;
    assign w_data = w_load_p0 ? w_rd_data : '0;

    // valid/address tag follows each activation read to its result write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= act_rd_en;
            addr_p[0] <= act_rd_addr;
            for (int i = 1; i < PIPE; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    assign res_wr_en   = vld_p[PIPE-1];
    assign res_wr_addr = vld_p[PIPE-1] ? addr_p[PIPE-1] : '0;

    // left-edge skew: row r is delayed r+1 cycles; idle slots carry zeros
    for (genvar r = 0; r < N; r++) begin : g_skew
        logic signed [data_size-1:0] sk_p [r+1];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= r; j++) sk_p[j] <= '0;
            end else begin
                sk_p[0] <= vld_p[0] ? $signed(act_rd_data[r*data_size +: data_size]) : '0;
                for (int j = 1; j <= r; j++) sk_p[j] <= sk_p[j-1];
            end
        end
        assign array_a[r*data_size +: data_size] = sk_p[r];
    end

    // bottom-edge deskew: column c waits N-1-c cycles so the vector lines up
    for (genvar c = 0; c < N; c++) begin : g_deskew
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_pass
            assign res_cols[c*data_size +: data_size] = array_c_out[c*data_size +: data_size];
        end else begin : g_dly
            logic signed [data_size-1:0] ds_p [D];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < D; j++) ds_p[j] <= '0;
                end else begin
                    ds_p[0] <= $signed(array_c_out[c*data_size +: data_size]);
                    for (int j = 1; j < D; j++) ds_p[j] <= ds_p[j-1];
                end
            end
            assign res_cols[c*data_size +: data_size] = ds_p[D-1];
        end
    end

    assign res_wr_data = res_wr_en ? res_cols : '0;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: buffer memories and an N x N MAC array model around the DUT,
// with a result scoreboard filled at job launch.
module tb_systolic_sequencer;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    num_vec;
    logic             busy, done;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic [N*W-1:0]   w_rd_data;
    logic             w_load;
    logic [1:0]       w_row;
    logic [N*W-1:0]   w_data;
    logic             act_rd_en;
    logic [AW-1:0]    act_rd_addr;
    logic [N*W-1:0]   act_rd_data;
    logic [N*W-1:0]   array_a;
    logic [N*W-1:0]   array_c_out;
    logic             res_wr_en;
    logic [AW-1:0]    res_wr_addr;
    logic [N*W-1:0]   res_wr_data;

    systolic_sequencer #(.N(N), .data_size(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .w_load(w_load), .w_row(w_row), .w_data(w_data),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .array_a(array_a), .array_c_out(array_c_out),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int wv [N][N];
    int av [16][N];
    logic [N*W-1:0] w_mem [N];
    logic [N*W-1:0] a_mem [16];

    typedef struct {
        int            addr;
        logic [N*W-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb_q [$];

    // buffers with one-cycle read latency
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr[1:0]];
        if (act_rd_en) act_rd_data <= a_mem[act_rd_addr[3:0]];
    end

    // array of element cells: out_c <= in_c + in_a*weight, in_a forwarded right
    logic signed [W-1:0] wt [N][N];
    logic signed [W-1:0] ma [N][N];
    logic signed [W-1:0] mc [N][N];
    logic signed [W-1:0] ia, ic;

    always @(posedge clk) begin
        if (w_load)
            for (int c = 0; c < N; c++) wt[w_row][c] <= w_data[c*W +: W];
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ia = (c == 0) ? array_a[r*W +: W] : ma[r][c-1];
                ic = (r == 0) ? '0 : mc[r-1][c];
                if (reset) begin
                    ma[r][c] <= '0;
                    mc[r][c] <= '0;
                end else begin
                    ma[r][c] <= ia;
                    mc[r][c] <= ic + ia * wt[r][c];
                end
            end
        end
    end

    always_comb begin
        array_c_out = '0;
        for (int c = 0; c < N; c++) array_c_out[c*W +: W] = mc[N-1][c];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic load_mems();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) w_mem[r][c*W +: W] = W'(wv[r][c]);
        for (int s = 0; s < 16; s++)
            for (int r = 0; r < N; r++) a_mem[s][r*W +: W] = W'(av[s][r]);
    endtask

    task automatic set_w(input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (kind)
                    0:       wv[r][c] = (r == c) ? 1 : 0;
                    1:       wv[r][c] = 2;
                    default: wv[r][c] = int'($urandom_range(0, 255)) - 128;
                endcase
        load_mems();
    endtask

    task automatic set_v(input int s, input int e0, input int e1, input int e2, input int e3);
        av[s][0] = e0; av[s][1] = e1; av[s][2] = e2; av[s][3] = e3;
        load_mems();
    endtask

    function automatic logic [N*W-1:0] exp_vec(input int s);
        logic [N*W-1:0]  v;
        logic signed [W-1:0] acc;
        v = '0;
        for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int r = 0; r < N; r++) acc = W'(int'(acc) + av[s][r] * wv[r][c]);
            v[c*W +: W] = acc;
        end
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, busy, done, w_rd_en, w_load, act_rd_en, res_wr_en}, 64'd0);
        chk({tag, "_dat"}, {63'd0, |{array_a, res_wr_data, w_data, w_rd_addr, act_rd_addr,
                                    res_wr_addr, w_row}}, 64'd0);
    endtask

    // Runs one job from its start cycle (rel 0) to its done cycle; optionally chains the
    // next start into the done cycle, drives ignored starts, or aborts with reset.
    task automatic run_job(input int m, input bit chained, input bit noise,
                           input bit chain_next, input int next_m, input int abort_at);
        int t0;
        int last;
        exp_t e;
        logic [W-1:0] ev;
        if (!chained) begin
            @(negedge clk);
            start   = 1'b1;
            num_vec = AW'(m);
        end
        t0   = cyc;
        last = 3 * N + m + 2;
        for (int s = 0; s < m; s++) begin
            e.addr = s;
            e.data = exp_vec(s);
            e.cyc  = t0 + 3 * N + 2 + s;
            sb_q.push_back(e);
        end
        for (int rel = 1; rel <= last; rel++) begin
            @(negedge clk);
            if (rel == last) begin
                start   = chain_next;
                num_vec = AW'(next_m);
            end else if (noise) begin
                start   = 1'b1;
                num_vec = AW'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            chk("busy", {63'd0, busy}, {63'd0, rel <= last - 1});
            chk("done", {63'd0, done}, {63'd0, rel == last});
            chk("w_rd_en", {63'd0, w_rd_en}, {63'd0, rel >= 1 && rel <= N});
            if (rel >= 1 && rel <= N) chk("w_rd_addr", 64'(w_rd_addr), 64'(rel - 1));
            chk("w_load", {63'd0, w_load}, {63'd0, rel >= 2 && rel <= N + 1});
            if (rel >= 2 && rel <= N + 1) begin
                chk("w_row", 64'(w_row), 64'(rel - 2));
                chk("w_data", 64'(w_data), 64'(w_mem[rel - 2]));
            end
            chk("act_rd_en", {63'd0, act_rd_en}, {63'd0, rel >= N + 1 && rel <= N + m});
            if (rel >= N + 1 && rel <= N + m) chk("act_rd_addr", 64'(act_rd_addr), 64'(rel - N - 1));
            for (int r = 0; r < N; r++) begin
                int s;
                s  = rel - (N + 3 + r);
                ev = (s >= 0 && s < m) ? W'(av[s][r]) : '0;
                chk("array_a", 64'(array_a[r*W +: W]), 64'(ev));
            end
            chk("res_wr_en", {63'd0, res_wr_en}, {63'd0, rel >= 3 * N + 2 && rel <= 3 * N + m + 1});
            if (res_wr_en) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_wr_addr", 64'(res_wr_addr), 64'(e.addr));
                    chk("res_wr_data", 64'(res_wr_data), 64'(e.data));
                    chk("res_wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (rel == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_all_zero("abort");
                sb_q.delete();
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk_all_zero("after_abort");
                end
                return;
            end
        end
        chk("sb_left", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        num_vec = '0;
        for (int s = 0; s < 16; s++)
            for (int r = 0; r < N; r++) av[s][r] = 0;
        set_w(0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // identity weights: results equal the inputs
        set_v(0, 1, 2, 3, 4);
        set_v(1, -1, 0, 5, 7);
        set_v(2, 8, 8, 8, 8);
        run_job(3, 1'b0, 1'b0, 1'b0, 0, 0);

        // all weights 2: 100*2 wraps to -56 in every column
        set_w(1);
        set_v(0, 100, 0, 0, 0);
        set_v(1, -3, 5, -7, 9);
        run_job(2, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("wrap_const", 64'(exp_vec(0)), 64'({4{8'hC8}}));

        // single vector, random weights
        set_w(2);
        set_v(0, 1, 2, 3, 4);
        run_job(1, 1'b0, 1'b0, 1'b0, 0, 0);

        // empty job completes in one cycle with no buffer traffic
        @(negedge clk);
        start   = 1'b1;
        num_vec = '0;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", {63'd0, done}, 64'd1);
        chk("empty_busy", {63'd0, busy}, 64'd0);
        chk("empty_rd", {62'd0, w_rd_en, act_rd_en}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("empty_quiet", {60'd0, busy, done, w_rd_en, act_rd_en}, 64'd0);
            chk("empty_no_wr", {63'd0, res_wr_en}, 64'd0);
        end

        // starts during a job are ignored
        set_w(0);
        set_v(0, 1, 2, 3, 4);
        set_v(1, -1, 0, 5, 7);
        set_v(2, 8, 8, 8, 8);
        run_job(3, 1'b0, 1'b1, 1'b0, 0, 0);

        // reset in cycle 8 aborts, then a fresh job runs normally
        set_w(2);
        run_job(3, 1'b0, 1'b0, 1'b0, 0, 8);
        run_job(3, 1'b0, 1'b0, 1'b0, 0, 0);

        // back-to-back: second start accepted in the done cycle of the first
        for (int s = 0; s < 5; s++)
            set_v(s, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        set_w(2);
        run_job(2, 1'b0, 1'b0, 1'b1, 5, 0);
        set_w(2);
        run_job(5, 1'b1, 1'b0, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        chk_all_zero("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
